// File: rtl/ram_output_arbiter_pkg.sv
// ram_output_pkg: shared types for the output-result RAM arbiter.
//   state_e     : arbiter FSM states (normal arbitration / zero-fill sequence)
//   requester_e : identifies the two RAM requesters; the value doubles as the
//                 bit index into the arbiter request/grant vectors
package ram_output_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } requester_e;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/ram_output_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   req   : request vector, bit REQ_WR = writer, bit REQ_RD = reader
//   en    : arbitration enable; no grant is issued while low
//   gnt   : one-hot (or zero) grant vector, combinational
// The last_served register moves only on an enabled grant, so cycles spent
// disabled (reset, clear sequence) leave the fairness order untouched.
module rr_arb2
  import ram_output_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic         en,
  output logic [1:0]   gnt
);

  requester_e r_last_served;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Conflict: serve whoever was not served most recently.
        2'b11:   gnt = (r_last_served == REQ_RD) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_served <= REQ_RD;
    end else if (gnt[REQ_WR]) begin
      r_last_served <= REQ_WR;
    end else if (gnt[REQ_RD]) begin
      r_last_served <= REQ_RD;
    end
  end

endmodule

// File: rtl/ram_output_arbiter.sv
// ram_output_arbiter: owns the single port of the output-result RAM.
// Shares it between a writer (result producer) and a reader (readout path)
// with round-robin fairness, aligns read responses to the RAM's one-cycle
// registered-address latency, and runs a zero-fill sequence on command.
//   clk, rst_n          : clock / synchronous active-low reset
//   wr_req/addr/data    : write request, held stable until wr_gnt
//   wr_gnt              : write accepted this cycle (combinational)
//   rd_req/addr         : read request, held stable until rd_gnt
//   rd_gnt              : read accepted this cycle (combinational)
//   rd_data, rd_valid   : read response, one cycle after rd_gnt
//   clr_start           : single-cycle clear command
//   clr_busy, clr_done  : clear in progress / one-cycle completion pulse
//   ram_data/addr/we    : RAM port drive
//   ram_q               : RAM read data
module ram_output_arbiter
  import ram_output_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  r_rd_valid;
  logic                  r_clr_done;
  logic                  w_clr_done_nxt;
  logic                  w_arb_en;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;

  // Arbitration only happens in IDLE outside reset, and a clear command
  // pre-empts any request in the same cycle.
  assign w_arb_en        = rst_n && (r_state == S_IDLE) && !clr_start;
  assign w_req[REQ_WR]   = wr_req;
  assign w_req[REQ_RD]   = rd_req;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .en    (w_arb_en),
    .gnt   (w_gnt)
  );

  assign wr_gnt = w_gnt[REQ_WR];
  assign rd_gnt = w_gnt[REQ_RD];

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_clr_done_nxt = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_data       = '0;

    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end else if (w_gnt[REQ_WR]) begin
          ram_we   = 1'b1;
          ram_addr = wr_addr;
          ram_data = wr_data;
        end else if (w_gnt[REQ_RD]) begin
          ram_addr = rd_addr;
        end
      end

      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = r_clr_cnt;
        ram_data = '0;
        // Terminal count holds rather than wrapping; the state change ends
        // the sequence.
        if (r_clr_cnt == '1) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // RAM port is quiesced while reset is held, including mid-clear.
    if (!rst_n) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_rd_valid <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_rd_valid <= w_gnt[REQ_RD];
      r_clr_done <= w_clr_done_nxt;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = ram_q;
  assign clr_busy = (r_state == S_CLEAR);
  assign clr_done = r_clr_done;

endmodule

// File: tb/tb_ram_output_arbiter.sv
module tb_ram_output_arbiter;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_gnt;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic       rd_gnt;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       clr_start;
  logic       clr_busy;
  logic       clr_done;
  logic [7:0] ram_data;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  int errors = 0;
  int checks = 0;

  // Behavioural single-port RAM: write at the edge, registered read address.
  logic [7:0] mem [16];
  logic [3:0] addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  ram_output_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    #1;
    chk("wr_gnt", 32'(wr_gnt), 1);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_req = 1'b1; rd_addr = a;
    #1;
    chk({tag, "_gnt"}, 32'(rd_gnt), 1);
    tick();
    rd_req = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(rd_valid), 1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; clr_start = 1'b0;

    // Reset: combinational outputs forced low even with a request present.
    tick();
    wr_req = 1'b1; wr_addr = 4'd5; wr_data = 8'h66;
    #1;
    chk("rst_wr_gnt", 32'(wr_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    wr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);

    // Write 0xA5 @3 then read @3 next cycle.
    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    #1;
    chk("w3_gnt", 32'(wr_gnt), 1);
    chk("w3_we", 32'(ram_we), 1);
    chk("w3_addr", 32'(ram_addr), 3);
    chk("w3_data", 32'(ram_data), 'hA5);
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 4'd3;
    #1;
    chk("r3_gnt", 32'(rd_gnt), 1);
    chk("r3_we", 32'(ram_we), 0);
    chk("r3_addr", 32'(ram_addr), 3);
    chk("r3_valid_early", 32'(rd_valid), 0);
    tick();
    rd_req = 1'b0;
    #1;
    chk("r3_valid", 32'(rd_valid), 1);
    chk("r3_data", 32'(rd_data), 'hA5);
    tick();
    chk("r3_valid_drop", 32'(rd_valid), 0);

    // Round robin after reset: writer first, then alternate.
    do_reset();
    wr_req = 1'b1; wr_addr = 4'd9; wr_data = 8'h77;
    rd_req = 1'b1; rd_addr = 4'd9;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_wr_gnt", 32'(wr_gnt), (i % 2 == 0) ? 1 : 0);
      chk("rr_rd_gnt", 32'(rd_gnt), (i % 2 == 1) ? 1 : 0);
      tick();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();

    // Preload 0x11..0x14 then back-to-back reads.
    for (int i = 0; i < 4; i++) do_write(4'(i), 8'(8'h11 + i));
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = 4'(i);
      #1;
      chk("b2b_gnt", 32'(rd_gnt), 1);
      if (i > 0) begin
        chk("b2b_valid", 32'(rd_valid), 1);
        chk("b2b_data", 32'(rd_data), 'h11 + i - 1);
      end
      tick();
    end
    rd_req = 1'b0;
    #1;
    chk("b2b_valid_last", 32'(rd_valid), 1);
    chk("b2b_data_last", 32'(rd_data), 'h14);
    tick();
    chk("b2b_valid_end", 32'(rd_valid), 0);

    // Fill with 0xFF, then clear; clr_start during CLEAR is ignored.
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'hFF);
    clr_start = 1'b1;
    #1;
    chk("clr_cmd_we", 32'(ram_we), 0);
    chk("clr_cmd_busy", 32'(clr_busy), 0);
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clr_start = (k == 3);
      #1;
      chk("clr_busy", 32'(clr_busy), 1);
      chk("clr_we", 32'(ram_we), 1);
      chk("clr_addr", 32'(ram_addr), 32'(k));
      chk("clr_data", 32'(ram_data), 0);
      chk("clr_done_early", 32'(clr_done), 0);
      tick();
    end
    clr_start = 1'b0;
    #1;
    chk("clr_busy_end", 32'(clr_busy), 0);
    chk("clr_done", 32'(clr_done), 1);
    tick();
    chk("clr_done_pulse", 32'(clr_done), 0);
    chk("clr_busy_stay", 32'(clr_busy), 0);
    do_read("clr_rd0", 4'd0, 8'h00);
    do_read("clr_rd9", 4'd9, 8'h00);
    do_read("clr_rd15", 4'd15, 8'h00);
    tick();

    // Clear and write requested together: write waits out the clear.
    clr_start = 1'b1;
    wr_req = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    #1;
    chk("cw_gnt_cmd", 32'(wr_gnt), 0);
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("cw_gnt_blocked", 32'(wr_gnt), 0);
      chk("cw_busy", 32'(clr_busy), 1);
      tick();
    end
    #1;
    chk("cw_gnt_idle", 32'(wr_gnt), 1);
    chk("cw_addr", 32'(ram_addr), 7);
    chk("cw_busy_end", 32'(clr_busy), 0);
    tick();
    wr_req = 1'b0;
    do_read("cw_rd7", 4'd7, 8'h3C);

    // Read granted just before clear entry, then reset at clear cycle 5.
    do_write(4'd8, 8'h5A);
    do_write(4'd5, 8'h55);
    do_write(4'd2, 8'h22);
    rd_req = 1'b1; rd_addr = 4'd8;
    #1;
    chk("pre_rd_gnt", 32'(rd_gnt), 1);
    tick();
    rd_req = 1'b0;
    clr_start = 1'b1;
    #1;
    chk("pre_rd_valid", 32'(rd_valid), 1);
    chk("pre_rd_data", 32'(rd_data), 'h5A);
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(ram_we), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(clr_busy), 0);
    chk("mid_rst_done", 32'(clr_done), 0);
    tick();
    chk("mid_rst_done2", 32'(clr_done), 0);
    do_read("pc_rd2", 4'd2, 8'h00);
    do_read("pc_rd4", 4'd4, 8'h00);
    do_read("pc_rd5", 4'd5, 8'h55);
    do_read("pc_rd8", 4'd8, 8'h5A);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_output_arbiter.md
Name: ram_output_arbiter

Overview:
- Owns the single port of the output-result RAM and shares it between two requesters.
  - A write requester: the result producer.
  - A read requester: the readout path.
- Arbitrates one access per cycle with round-robin fairness.
- Aligns read responses to the RAM's one-cycle registered-address read latency.
- Provides a clear sequencer that zero-fills the whole RAM on command.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_req  in  1  write request; wr_addr/wr_data held stable until granted
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- rd_req  in  1  read request; rd_addr held stable until granted
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_data  out  DATA_WIDTH  read data, meaningful only while rd_valid=1
- rd_valid  out  1  registered; high exactly one cycle after each rd_gnt
- clr_start  in  1  single-cycle clear command
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle registered pulse after the last clear write
- ram_data  out  DATA_WIDTH  to RAM data
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_we  out  1  to RAM we
- ram_q  in  DATA_WIDTH  from RAM q

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, clr_cnt=0, rd_valid=0, clr_done=0.
  - last_served=RD, so the writer wins the first conflict.
- While rst_n=0, the combinational outputs are forced: wr_gnt=0, rd_gnt=0, ram_we=0, ram_addr=0, ram_data=0.
- States are IDLE and CLEAR.
- IDLE, no clr_start:
  - Only wr_req: wr_gnt=1, ram_we=1, ram_addr=wr_addr, ram_data=wr_data.
  - Only rd_req: rd_gnt=1, ram_we=0, ram_addr=rd_addr.
  - Both requesting: grant the requester not equal to last_served.
  - last_served updates on every grant.
  - No request: ram_we=0, ram_addr=0, ram_data=0.
- Transfer occurs when req&&gnt. At most one grant is asserted per cycle.
- Read latency:
  - rd_valid is registered rd_gnt.
  - rd_data = ram_q combinationally, valid in the cycle rd_valid=1 only.
  - Back-to-back reads yield one rd_valid per cycle, in order.
- Write followed by read of the same address in the next cycle returns the new data. The RAM write commits at the grant edge.
- IDLE with clr_start=1:
  - Clear has priority; no grants that cycle.
  - Next state is CLEAR, clr_cnt=0.
  - clr_busy=1 from the next cycle.
- CLEAR, each cycle:
  - ram_we=1, ram_addr=clr_cnt, ram_data=0, wr_gnt=rd_gnt=0.
  - clr_cnt increments.
  - At clr_cnt==2**ADDR_WIDTH-1: go to IDLE, clr_done=1 next cycle for exactly 1 cycle, clr_busy=0.
  - Total busy time is 2**ADDR_WIDTH cycles. The counter never wraps.
- clr_start while in CLEAR is ignored.
- Requests pending during CLEAR remain pending and are arbitrated normally from the first IDLE cycle.
- A read granted in the cycle before CLEAR entry still produces rd_valid with the pre-clear data.
- rst_n=0 mid-clear:
  - Return to IDLE, clr_busy=0, no clr_done.
  - RAM contents are left partially cleared.
  - A pending rd_valid is dropped.
- last_served is unaffected by CLEAR.

Decomposition:
- Package ram_output_pkg:
  - state enum {S_IDLE, S_CLEAR}.
  - requester enum {REQ_WR, REQ_RD}.
- Sub-module rr_arb2: two-way round-robin arbiter.
  - Inputs: req[1:0], en.
  - Outputs: gnt[1:0].
  - Holds the last_served register, updated only on an enabled grant.
- The parent holds the FSM, clr_cnt, the rd_valid register and the RAM-side mux.

Test Plan:
- Write 0xA5 @3, then read @3 on the next cycle: rd_gnt at cycle N, rd_valid=1 and rd_data=0xA5 at N+1.
- Both requesters held continuously for 6 cycles after reset: grants alternate WR,RD,WR,RD,WR,RD.
- Preload 0x11..0x14 @0..3, then back-to-back reads @0,1,2,3: rd_valid is high 4 consecutive cycles with data 0x11,0x12,0x13,0x14.
- Fill all 16 words with 0xFF, pulse clr_start: clr_busy=1 for 16 cycles, ram_we=1 with addr 0..15, then clr_done pulse; subsequent reads return 0x00.
- clr_start asserted together with wr_req: no wr_gnt until clr_busy falls; write 0x3C @7 then completes in the first IDLE cycle and reads back 0x3C.
- rst_n=0 at clear cycle 5: clr_busy=0, no clr_done; addrs 0..4 read 0x00 and addr 8 retains its preload.
